// File: rtl/plane_unloader_if.sv
// -----------------------------------------------------------------------------
// plane_unloader_if
// Output word stream of the plane unloader: one LENGTH-bit word per PE,
// moved by a valid/ready handshake.
//   out_valid  : out_data/out_pe hold a word (driven by master)
//   out_ready  : downstream accepts the word (driven by slave)
//   out_data   : word of PE out_pe; bit k comes from plane base+k
//   out_pe     : PE index of out_data
//   out_parity : XOR of out_data, present only when UNLOAD_PARITY_EN is defined
// -----------------------------------------------------------------------------
interface plane_unloader_if #(
  parameter int LENGTH = 32,
  parameter int PES    = 16
);
  localparam int PE_W = (PES > 1) ? $clog2(PES) : 1;

  logic              out_valid;
  logic              out_ready;
  logic [LENGTH-1:0] out_data;
  logic [PE_W-1:0]   out_pe;
`ifdef UNLOAD_PARITY_EN
  logic              out_parity;
`endif

  modport master (
    output out_valid,
    output out_data,
    output out_pe,
`ifdef UNLOAD_PARITY_EN
    output out_parity,
`endif
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_pe,
`ifdef UNLOAD_PARITY_EN
    input  out_parity,
`endif
    output out_ready
  );
endinterface

// File: rtl/plane_unloader.sv
// -----------------------------------------------------------------------------
// plane_unloader
// Corner-turn readback engine. Reads LENGTH bit-planes (PES bits each) of one
// vector register from the plane memory, transposes them into PES words of
// LENGTH bits and streams the words out one PE at a time.
//
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous, active-low reset
//   start    : request a readback (sampled only in IDLE)
//   reg_sel  : register index; base address = reg_sel*LENGTH (truncated)
//   addr/ren : plane-memory read address / read enable
//   DOA      : plane-memory read data, valid one cycle after addr/ren
//   busy     : high in every state except IDLE
//   done     : one-cycle pulse after the last word is accepted
//   out_if   : word stream (master side)
//
// Optional feature: define UNLOAD_PARITY_EN to add out_if.out_parity, the XOR
// of out_data, timed with out_data.
// -----------------------------------------------------------------------------
module plane_unloader #(
  parameter int LENGTH = 32,
  parameter int PES    = 16,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [4:0]          reg_sel,
  output logic [ADDR_W-1:0]   addr,
  output logic                ren,
  input  logic [PES-1:0]      DOA,
  output logic                busy,
  output logic                done,
  plane_unloader_if.master    out_if
);
  localparam int K_W  = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int PE_W = (PES > 1) ? $clog2(PES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_EMIT,
    ST_DONE
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  base;
  logic [K_W-1:0]     k;       // index of the plane address on addr this cycle
  logic [PE_W-1:0]    pe;
  logic [LENGTH-1:0]  word_q [PES];

  logic               cap_en;
  logic [K_W-1:0]     cap_idx;
  logic [ADDR_W-1:0]  start_base;
  logic [LENGTH-1:0]  first_word;
  logic [LENGTH-1:0]  next_word;

  // DOA always carries the plane addressed in the previous cycle, so the
  // capture index lags k by one; DRAIN picks up the last plane.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    cap_en     = 1'b0;
    cap_idx    = k - K_W'(1);
    start_base = ADDR_W'(32'(reg_sel) * LENGTH);
    if (state == ST_READ && k != '0) cap_en = 1'b1;
    if (state == ST_DRAIN) begin
      cap_en  = 1'b1;
      cap_idx = K_W'(LENGTH - 1);
    end
    // The first word is registered in DRAIN, while its top bit is still on DOA.
    first_word             = word_q[0];
    first_word[LENGTH-1]   = DOA[0];
    next_word              = word_q[pe + PE_W'(1)];
  end

  // NOTE: the word store is a plain array with no reset; every bit is
  // rewritten during READ/DRAIN before it is ever emitted.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      for (int j = 0; j < PES; j++) word_q[j][cap_idx] <= DOA[j];
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      base             <= '0;
      k                <= '0;
      pe               <= '0;
      addr             <= '0;
      ren              <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      out_if.out_valid <= 1'b0;
      out_if.out_data  <= '0;
      out_if.out_pe    <= '0;
`ifdef UNLOAD_PARITY_EN
      out_if.out_parity <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            base  <= start_base;
            addr  <= start_base;
            k     <= '0;
            ren   <= 1'b1;
            busy  <= 1'b1;
            state <= ST_READ;
          end
        end
        ST_READ: begin
          if (k == K_W'(LENGTH - 1)) begin
            ren   <= 1'b0;
            state <= ST_DRAIN;
          end else begin
            k    <= k + K_W'(1);
            addr <= base + ADDR_W'(k) + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          pe               <= '0;
          out_if.out_valid <= 1'b1;
          out_if.out_pe    <= '0;
          out_if.out_data  <= first_word;
`ifdef UNLOAD_PARITY_EN
          out_if.out_parity <= ^first_word;
`endif
          state            <= ST_EMIT;
        end
        ST_EMIT: begin
          // out_valid is high throughout EMIT, so out_ready alone marks a handshake.
          if (out_if.out_ready) begin
            if (pe == PE_W'(PES - 1)) begin
              out_if.out_valid <= 1'b0;
              done             <= 1'b1;
              state            <= ST_DONE;
            end else begin
              pe              <= pe + PE_W'(1);
              out_if.out_pe   <= pe + PE_W'(1);
              out_if.out_data <= next_word;
`ifdef UNLOAD_PARITY_EN
              out_if.out_parity <= ^next_word;
`endif
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_plane_unloader.sv
// -----------------------------------------------------------------------------
// tb_plane_unloader
// Self-checking bench for plane_unloader. A registered-read memory model feeds
// DOA; expected words are computed directly from the memory contents as the
// transpose of the addressed planes. Covers reset values, uniform and walking
// patterns, back-pressure, the top register, start during EMIT and reset
// in the middle of READ.
// -----------------------------------------------------------------------------
module tb_plane_unloader;
  localparam int LENGTH = 32;
  localparam int PES    = 16;
  localparam int ADDR_W = 10;
  localparam int MEM_D  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [4:0]        reg_sel;
  logic [ADDR_W-1:0] addr;
  logic              ren;
  logic [PES-1:0]    DOA;
  logic              busy;
  logic              done;

  plane_unloader_if #(.LENGTH(LENGTH), .PES(PES)) out_if ();

  plane_unloader #(.LENGTH(LENGTH), .PES(PES), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .reg_sel (reg_sel),
    .addr    (addr),
    .ren     (ren),
    .DOA     (DOA),
    .busy    (busy),
    .done    (done),
    .out_if  (out_if)
  );

  always #5 clk = ~clk;

  // Registered-read plane memory.
  logic [PES-1:0] mem [MEM_D];
  always @(posedge clk) if (ren) DOA <= mem[addr];

  int n_vec = 0;
  int n_err = 0;
  logic [LENGTH-1:0] last_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word of PE j: bit k is bit j of plane base+k.
  function automatic logic [LENGTH-1:0] model_word(input int base, input int j);
    logic [LENGTH-1:0] w;
    logic [PES-1:0]    plane;
    for (int b = 0; b < LENGTH; b++) begin
      plane = mem[(base + b) % MEM_D];
      w[b]  = plane[j];
    end
    return w;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < MEM_D; i++) mem[i] = PES'($urandom);
  endtask

  task automatic fill_uniform();
    for (int i = 0; i < MEM_D; i++) mem[i] = '0;
    mem[13] = 16'hFFFF;
    mem[16] = 16'hFFFF;
    mem[19] = 16'hFFFF;
  endtask

  task automatic fill_walking();
    fill_random();
    for (int b = 0; b < LENGTH; b++) mem[2 * LENGTH + b] = PES'(1) << (b % PES);
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: random ready.
  task automatic run(input logic [4:0] rs, input int mode, input bit poke_start,
                     input bit check_cycles);
    int base;
    logic [LENGTH-1:0] exp_w [PES];
    int cyc, issued, first_rd, first_val, exp_pe, last_hs, rpat;
    bit stalled, fin, r;
    bit pat [4];
    logic [LENGTH-1:0] held_d;
    logic [3:0] held_p;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    base = (int'(rs) * LENGTH) % MEM_D;
    for (int j = 0; j < PES; j++) exp_w[j] = model_word(base, j);
    cyc = 0; issued = 0; first_rd = -1; first_val = -1; exp_pe = 0; last_hs = -1;
    rpat = 0; stalled = 0; fin = 0; held_d = '0; held_p = '0;

    @(negedge clk);
    start   = 1'b1;
    reg_sel = rs;
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = poke_start && (cyc == 40);
      if (ren) begin
        if (first_rd < 0) first_rd = cyc;
        check("addr", 64'(addr), 64'(base + issued));
        issued++;
      end
      if (out_if.out_valid) begin
        check("busy_emit", 64'(busy), 64'(1));
        if (first_val < 0) begin
          first_val = cyc;
          check("latency", 64'(cyc), 64'(LENGTH + 2));
        end
        if (stalled) begin
          check("hold_data", 64'(out_if.out_data), 64'(held_d));
          check("hold_pe", 64'(out_if.out_pe), 64'(held_p));
        end
        case (mode)
          0:       r = 1'b1;
          1:       r = pat[rpat % 4];
          default: r = 1'($urandom_range(0, 1));
        endcase
        rpat++;
        out_if.out_ready = r;
        if (r) begin
          check("pe", 64'(out_if.out_pe), 64'(exp_pe));
          check("data", 64'(out_if.out_data), 64'(exp_w[exp_pe % PES]));
`ifdef UNLOAD_PARITY_EN
          check("parity", 64'(out_if.out_parity), 64'(^exp_w[exp_pe % PES]));
`endif
          last_data = out_if.out_data;
          exp_pe++;
          last_hs = cyc;
          stalled = 0;
        end else begin
          stalled = 1;
          held_d  = out_if.out_data;
          held_p  = out_if.out_pe;
        end
      end else begin
        if (stalled) check("valid_drop", 64'(0), 64'(1));
        stalled = 0;
        out_if.out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (done) begin
        check("done_after_hs", 64'(cyc), 64'(last_hs + 1));
        fin = 1;
      end
    end
    start = 1'b0;
    check("timeout", 64'(fin), 64'(1));
    check("reads", 64'(issued), 64'(LENGTH));
    check("first_read", 64'(first_rd), 64'(1));
    check("words", 64'(exp_pe), 64'(PES));
    if (check_cycles) check("done_cycle", 64'(cyc), 64'(LENGTH + 2 + PES));
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_done", 64'(done), 64'(0));
    check("idle_valid", 64'(out_if.out_valid), 64'(0));
    if (poke_start) begin
      repeat (3) begin
        @(negedge clk);
        check("no_rerun_ren", 64'(ren), 64'(0));
        check("no_rerun_busy", 64'(busy), 64'(0));
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, 64'(addr), 64'(0));
    check({tag, "_ren"}, 64'(ren), 64'(0));
    check({tag, "_valid"}, 64'(out_if.out_valid), 64'(0));
    check({tag, "_data"}, 64'(out_if.out_data), 64'(0));
    check({tag, "_pe"}, 64'(out_if.out_pe), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
`ifdef UNLOAD_PARITY_EN
    check({tag, "_parity"}, 64'(out_if.out_parity), 64'(0));
`endif
  endtask

  task automatic reset_mid_read();
    fill_random();
    @(negedge clk);
    start   = 1'b1;
    reg_sel = 5'($urandom);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);   // now in cycle 10, mid-READ
    check("pre_reset_busy", 64'(busy), 64'(1));
    reset = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    reg_sel = '0;
    out_if.out_ready = 1'b1;
    for (int i = 0; i < MEM_D; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    @(negedge clk);

    fill_uniform();
    run(5'd0, 0, 1'b0, 1'b1);
    check("uniform_word", 64'(last_data), 64'(32'h00092000));

    fill_walking();
    run(5'd2, 0, 1'b0, 1'b1);
    check("walk_pe15", 64'(last_data), 64'(32'h00010001 << 15));

    fill_random();
    run(5'($urandom), 1, 1'b0, 1'b0);

    fill_random();
    run(5'd31, 0, 1'b1, 1'b1);

    reset_mid_read();
    run(5'($urandom), 2, 1'b0, 1'b0);

    for (int t = 0; t < 3; t++) begin
      fill_random();
      run(5'($urandom), 2, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
